// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the K=3, rate-1/2 code: sizes, generators,
// FSM encoding, and the single encoder step used by encoder and decoder tables.
package viterbi_pkg;

  localparam int MSG_W_DEF  = 8;
  localparam int CODE_W_DEF = 2 * MSG_W_DEF;

  // Taps are ordered {u, s1, s0}, s1 being the most recent previous bit
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef struct packed {
    logic       v0;
    logic       v1;
    logic [1:0] next_sreg;
  } step_t;

  function automatic step_t conv_step(input logic       u,
                                      input logic [1:0] sreg,
                                      input logic [2:0] g0,
                                      input logic [2:0] g1);
    step_t r;
    r.v0        = ^(g0 & {u, sreg});
    r.v1        = ^(g1 & {u, sreg});
    r.next_sreg = {u, sreg[1]};
    return r;
  endfunction

endpackage

// File: rtl/conv_enc.sv
// Rate-1/2 K=3 convolutional encoder: serialises a message MSB first into a packed codeword.
// Build option CONV_ENC_STATE_CARRY_EN keeps the trellis state across blocks.
module conv_enc
  import viterbi_pkg::*;
#(
  parameter int         MSG_W   = MSG_W_DEF,
  parameter logic [2:0] G0_POLY = G0,
  parameter logic [2:0] G1_POLY = G1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MSG_W-1:0]     msg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*MSG_W-1:0]   code,
  output logic                 busy,
  output state_e               dbg_state
);

  localparam int CODE_W = 2 * MSG_W;
  localparam int CNT_W  = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_W - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; in_ready is high only in IDLE, out_valid only in OUT, and the producer
  // holds its data stable while valid is high and ready is low.

  state_e              state_q, state_d;
  logic [MSG_W-1:0]    buf_q, buf_d;
  logic [1:0]          sreg_q, sreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  step_t               step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      sreg_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    step    = conv_step(buf_q[MSG_W-1], sreg_q, G0_POLY, G1_POLY);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = msg;
          code_d  = '0;
          cnt_d   = '0;
`ifdef CONV_ENC_STATE_CARRY_EN
          sreg_d  = sreg_q;
`else
          sreg_d  = '0;
`endif
          state_d = ENC;
        end
      end
      ENC: begin
        // Shifting pairs in from the right leaves the first pair at the top after MSG_W steps
        code_d = {code_q[CODE_W-3:0], step.v0, step.v1};
        sreg_d = step.next_sreg;
        buf_d  = buf_q << 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign code      = code_q;
  assign dbg_state = state_q;

endmodule
